// File: rtl/des_block_packer.sv
// Byte-stream to 64-bit block packer feeding the DES core: fills, pads, issues, then waits for dat_valid.
// Optional PKCS#7 padding (including the trailing all-08 block) is enabled by defining DES_PAD_EN.
module des_block_packer #(
  parameter bit MSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [63:0]      plain_text,
  output logic             start,
  input  logic             dat_valid,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [63:0] EXTRA_BLK = {8{8'h08}};

  typedef enum logic [2:0] {IDLE, FILL, PAD, ISSUE, WAIT} state_e;

  state_e           state_q;
  logic [2:0]       idx_q;
  logic [63:0]      pt_q;
  logic             start_q;
  logic             s_ready_q;
  logic             busy_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TW-1:0]    tmo_q;
`ifdef DES_PAD_EN
  logic             extra_q;
`endif

  logic [63:0]      fill_blk_d;
  logic [63:0]      pad_blk_d;

  // Byte position 0 is the first byte of the block; MSB_FIRST decides which lane that is.
  function automatic logic [63:0] put_byte(input logic [63:0] blk, input logic [2:0] pos,
                                           input logic [7:0] b);
    logic [63:0] r;
    logic [2:0]  lane;
    r    = blk;
    lane = MSB_FIRST ? (3'd7 - pos) : pos;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  // n is the number of bytes already written; positions n..7 receive the pad value.
  function automatic logic [63:0] pad_block(input logic [63:0] blk, input logic [2:0] n);
    logic [63:0] r;
    logic [7:0]  pv;
`ifdef DES_PAD_EN
    pv = 8'd8 - {5'd0, n};
`else
    pv = 8'h00;
`endif
    r = blk;
    for (int p = 0; p < 8; p++) begin
      if (p >= int'(n)) r = put_byte(r, 3'(p), pv);
    end
    return r;
  endfunction

  always_comb begin
    fill_blk_d = put_byte(pt_q, idx_q, s_data);
    pad_blk_d  = pad_block(pt_q, idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      pt_q      <= 64'd0;
      start_q   <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      tmo_q     <= '0;
`ifdef DES_PAD_EN
      extra_q   <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q   <= FILL;
          s_ready_q <= 1'b1;
          busy_q    <= 1'b1;
        end
        FILL: begin
          if (s_valid && s_ready_q) begin
            pt_q  <= fill_blk_d;
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q   <= ISSUE;
              start_q   <= 1'b1;
              s_ready_q <= 1'b0;
`ifdef DES_PAD_EN
              extra_q   <= s_last;
`endif
            end else if (s_last) begin
              state_q   <= PAD;
              s_ready_q <= 1'b0;
            end
          end
        end
        PAD: begin
          pt_q    <= pad_blk_d;
          state_q <= ISSUE;
          start_q <= 1'b1;
        end
        ISSUE: begin
          // A dat_valid coinciding with start is deliberately not sampled here.
          state_q <= WAIT;
          tmo_q   <= '0;
        end
        WAIT: begin
          if (dat_valid) begin
            cnt_q <= cnt_q + 1'b1;
            idx_q <= 3'd0;
`ifdef DES_PAD_EN
            if (extra_q) begin
              extra_q <= 1'b0;
              pt_q    <= EXTRA_BLK;
              state_q <= ISSUE;
              start_q <= 1'b1;
            end else begin
              state_q   <= FILL;
              s_ready_q <= 1'b1;
            end
`else
            state_q   <= FILL;
            s_ready_q <= 1'b1;
`endif
          end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST)) begin
            err_q     <= 1'b1;
            idx_q     <= 3'd0;
            state_q   <= FILL;
            s_ready_q <= 1'b1;
`ifdef DES_PAD_EN
            extra_q   <= 1'b0;
`endif
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign plain_text = pt_q;
  assign start      = start_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign blk_cnt    = cnt_q;

endmodule

// File: tb/tb_des_block_packer.sv
// Self-checking bench for des_block_packer: MSB-first and LSB-first instances driven in lockstep.
module tb_des_block_packer;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid, s_last, dat_valid;

  logic        m_ready, m_start, m_busy, m_err;
  logic [63:0] m_pt;
  logic [15:0] m_cnt;
  logic        l_ready, l_start, l_busy, l_err;
  logic [63:0] l_pt;
  logic [15:0] l_cnt;

  int total = 0;
  int passed = 0;
  int exp_cnt = 0;
  logic exp_err = 1'b0;
  bit stray_start = 1'b0;
`ifdef DES_PAD_EN
  bit pad_en = 1'b1;
`else
  bit pad_en = 1'b0;
`endif

  des_block_packer #(.MSB_FIRST(1'b1), .TIMEOUT_CYCLES(TMO), .CNT_W(16)) u_msb (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(m_ready), .plain_text(m_pt), .start(m_start), .dat_valid(dat_valid),
    .busy(m_busy), .err(m_err), .blk_cnt(m_cnt));

  des_block_packer #(.MSB_FIRST(1'b0), .TIMEOUT_CYCLES(TMO), .CNT_W(16)) u_lsb (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(l_ready), .plain_text(l_pt), .start(l_start), .dat_valid(dat_valid),
    .busy(l_busy), .err(l_err), .blk_cnt(l_cnt));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference block: message bytes in arrival order, then pad bytes, placed by byte order.
  function automatic logic [63:0] ref_block(input logic [7:0] b[$], input bit msb);
    logic [7:0]  full [8];
    logic [63:0] r;
    int n;
    n = b.size();
    for (int p = 0; p < 8; p++)
      full[p] = (p < n) ? b[p] : (pad_en ? 8'(8 - n) : 8'h00);
    r = 64'd0;
    if (msb) for (int p = 0; p < 8; p++) r = (r << 8) | 64'(full[p]);
    else     for (int p = 0; p < 8; p++) r = r | (64'(full[p]) << (8 * p));
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    bit ok;
    logic rdy;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      if (m_start || l_start) stray_start = 1'b1;
      tick();
    end
    s_valid = 1'b1; s_data = b; s_last = last;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      rdy = m_ready;
      if (m_start || l_start) stray_start = 1'b1;
      tick();
      ok = rdy;
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_ack(input logic [63:0] exp_m, input logic [63:0] exp_l, input bit extra);
    bit more, ex, bad;
    logic [63:0] em, el;
    logic [7:0] empty_q[$];
    int d;
    more = 1'b1; ex = extra; em = exp_m; el = exp_l;
    while (more) begin
      if ($urandom_range(0, 3) == 0) begin
        dat_valid = 1'b1;
        tick();
        dat_valid = 1'b0;
        check("ack_in_issue_cnt", 64'(m_cnt), 64'(16'(exp_cnt)));
        check("ack_in_issue_ready", 64'(m_ready), 64'd0);
      end else tick();
      check("start_one_cycle", {62'd0, m_start, l_start}, 64'd0);
      bad = 1'b0;
      d = $urandom_range(0, 8);
      for (int i = 0; i < d; i++) begin
        if (m_ready || l_ready || m_start || m_pt !== em || l_pt !== el) bad = 1'b1;
        tick();
      end
      check("wait_hold", 64'(bad), 64'd0);
      dat_valid = 1'b1;
      tick();
      dat_valid = 1'b0;
      exp_cnt++;
      check("blk_cnt_msb", 64'(m_cnt), 64'(16'(exp_cnt)));
      check("blk_cnt_lsb", 64'(l_cnt), 64'(16'(exp_cnt)));
      check("err_flag", 64'(m_err), 64'(exp_err));
      if (ex) begin
        ex = 1'b0;
        em = ref_block(empty_q, 1'b1);
        el = ref_block(empty_q, 1'b0);
        check("extra_start", {62'd0, m_start, l_start}, 64'd3);
        check("extra_pt_msb", m_pt, em);
        check("extra_pt_lsb", l_pt, el);
      end else begin
        more = 1'b0;
        check("ready_after_ack", 64'(m_ready), 64'd1);
      end
    end
  endtask

  task automatic issue_block(input logic [7:0] blk[$], input bit partial, input bit extra);
    logic [63:0] em, el;
    em = ref_block(blk, 1'b1);
    el = ref_block(blk, 1'b0);
    if (partial) begin
      check("pad_no_start", {62'd0, m_start, l_start}, 64'd0);
      check("pad_not_ready", 64'(m_ready), 64'd0);
      tick();
    end
    check("start_pulse", {62'd0, m_start, l_start}, 64'd3);
    check("pt_msb", m_pt, em);
    check("pt_lsb", l_pt, el);
    check("issue_not_ready", 64'(m_ready), 64'd0);
    wait_ack(em, el, extra);
  endtask

  task automatic run_msg(input logic [7:0] msg[$], input bit with_last, input int gap);
    logic [7:0] blk[$];
    int n, pos, cnt;
    bit is_end;
    n = msg.size();
    pos = 0;
    while (pos < n) begin
      cnt = (n - pos >= 8) ? 8 : n - pos;
      blk.delete();
      for (int k = 0; k < cnt; k++) blk.push_back(msg[pos + k]);
      is_end = (pos + cnt == n);
      for (int k = 0; k < cnt; k++)
        send_byte(blk[k], with_last && is_end && (k == cnt - 1),
                  (gap < 0) ? $urandom_range(0, 2) : gap);
      issue_block(blk, cnt < 8, pad_en && with_last && is_end && (cnt == 8));
      pos += cnt;
    end
    check("stray_start", 64'(stray_start), 64'd0);
    stray_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pt"}, m_pt | l_pt, 64'd0);
    check({tag, "_ctl"}, {58'd0, m_start, l_start, m_ready, l_ready, m_busy, l_busy}, 64'd0);
    check({tag, "_err_cnt"}, {31'd0, m_err, l_err, m_cnt, l_cnt}, 64'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] rq[$];
    bit early;
    rst_n = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; dat_valid = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check("fill_after_reset", {60'd0, m_ready, l_ready, m_busy, l_busy}, 64'hF);

    q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    run_msg(q, 1'b0, 0);
    q = '{8'hAA, 8'hBB, 8'hCC};
    run_msg(q, 1'b1, 0);
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_msg(q, 1'b1, 0);
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_msg(q, 1'b0, 1);

    for (int m = 0; m < 5; m++) begin
      rq.delete();
      for (int k = 0; k < int'($urandom_range(1, 19)); k++) rq.push_back(8'($urandom));
      run_msg(rq, 1'b1, -1);
    end

    // Core never answers: timeout must fire exactly TMO cycles into WAIT.
    for (int k = 0; k < 8; k++) send_byte(8'($urandom), 1'b0, 0);
    check("tmo_start", {62'd0, m_start, l_start}, 64'd3);
    early = 1'b0;
    for (int i = 0; i < TMO + 1; i++) begin
      if (m_err || l_err) early = 1'b1;
      tick();
    end
    exp_err = 1'b1;
    check("tmo_early", 64'(early), 64'd0);
    check("tmo_err", {62'd0, m_err, l_err}, 64'd3);
    check("tmo_cnt", 64'(m_cnt), 64'(16'(exp_cnt)));
    tick();
    check("tmo_ready_next", {62'd0, m_ready, l_ready}, 64'd3);
    check("tmo_err_sticky", 64'(m_err), 64'd1);

    // Asynchronous reset while a block is outstanding.
    for (int k = 0; k < 8; k++) send_byte(8'($urandom), 1'b0, 0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    dat_valid = 1'b1;
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
    exp_err = 1'b0;
    tick();
    dat_valid = 1'b0;
    check("post_reset_ready", {62'd0, m_ready, l_ready}, 64'd3);
    check("post_reset_cnt", 64'(m_cnt), 64'd0);
    q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    run_msg(q, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
